apu_frame_sequencer: RTL and testbench

Frame sequencer for the NES APU: divides the CPU-rate tick into frame steps and emits the quarter-frame and half-frame strobes that clock the envelope, linear, sweep and length-counter units. Its `oHalfFrame` drives the `iEnable` input of every `length_counter` instance. It implements the $4017 register behaviour: 4-step and 5-step modes, frame IRQ with inhibit, and acknowledge.

---
 rtl/apu_pkg.sv | 29 ++
 rtl/apu_frame_divider.sv | 46 ++++
 rtl/apu_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Package     : apu_pkg                                                    |
// | Description : Shared constants and types for the NES APU blocks: NTSC    |
// |               frame-step period, divider width, frame mode encoding and  |
// |               per-mode step counts.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package apu_pkg;

  localparam int APU_STEP_PERIOD_NTSC = 7457;
  localparam int APU_DIV_W            = 15;

  typedef enum logic {
    APU_MODE_4STEP = 1'b0,
    APU_MODE_5STEP = 1'b1
  } apuMode_t;

  localparam logic [2:0] APU_STEPS_4 = 3'd4;
  localparam logic [2:0] APU_STEPS_5 = 3'd5;

  // Index of the final step of a frame for the given mode.
  function automatic logic [2:0] apuLastStep(input apuMode_t mode);
    return (mode == APU_MODE_5STEP) ? (APU_STEPS_5 - 3'd1) : (APU_STEPS_4 - 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apu_frame_divider.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : apu_frame_divider                                          |
// | Description : Tick prescaler for the frame sequencer. Counts iTick       |
// |               pulses 0..STEP_PERIOD-1 and flags the tick that wraps it.  |
// | Ports       : iClk, iReset_n (async, active-low)                         |
// |               iTick      - CPU-rate enable pulse                         |
// |               iClear     - synchronous clear, overrides iTick            |
// |               oStepDone  - combinational, high on the wrapping tick      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module apu_frame_divider
  import apu_pkg::*;
#(
  parameter int STEP_PERIOD = APU_STEP_PERIOD_NTSC
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iTick,
  input  logic iClear,
  output logic oStepDone
);

  localparam logic [APU_DIV_W-1:0] c_DIV_LAST = APU_DIV_W'(STEP_PERIOD - 1);

  logic [APU_DIV_W-1:0] r_divider;
  logic                 w_atLast;

  assign w_atLast = (r_divider == c_DIV_LAST);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_divider <= '0;
    end else if (iClear) begin
      r_divider <= '0;
    end else if (iTick) begin
      r_divider <= w_atLast ? '0 : (r_divider + APU_DIV_W'(1));
    end
  end

  // A clear in the same cycle discards the step boundary.
  assign oStepDone = iTick & w_atLast & ~iClear;

endmodule
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : apu_frame_sequencer                                        |
// | Description : NES APU frame sequencer ($4017). Divides the CPU tick into |
// |               frame steps, emits quarter/half-frame strobes, and raises  |
// |               the frame IRQ in 4-step mode.                              |
// | Ports       : iClk, iReset_n (async, active-low)                         |
// |               iCpuTick    - one-cycle pulse per CPU cycle                |
// |               iWrite      - $4017 write strobe (iMode, iIrqInhibit)      |
// |               iIrqAck     - $4015 read strobe, clears the frame IRQ      |
// |               oQuarterFrame, oHalfFrame - one-cycle strobes              |
// |               oIrq        - frame IRQ level                              |
// |               oStep       - current step 0..4, oMode - latched mode      |
// | Config      : APU_FRAME_IRQ_EN - when defined, builds inhibit/IRQ logic; |
// |               otherwise oIrq is tied low.                                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int STEP_PERIOD = APU_STEP_PERIOD_NTSC
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iCpuTick,
  input  logic       iWrite,
  input  logic       iMode,
  input  logic       iIrqInhibit,
  input  logic       iIrqAck,
  output logic       oQuarterFrame,
  output logic       oHalfFrame,
  output logic       oIrq,
  output logic [2:0] oStep,
  output logic       oMode
);

  logic       w_stepDone;
  logic [2:0] w_stepNext;
  logic       w_quarter;
  logic       w_half;
  logic       w_irqSet;

  logic [2:0] r_step;
  apuMode_t   r_mode;
  logic       r_quarter;
  logic       r_half;

  apu_frame_divider #(
    .STEP_PERIOD (STEP_PERIOD)
  ) u_divider (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .iTick     (iCpuTick),
    .iClear    (iWrite),
    .oStepDone (w_stepDone)
  );

  // Step-end decode: what the step that is just finishing emits.
  always_comb begin
    w_stepNext = r_step;
    w_quarter  = 1'b0;
    w_half     = 1'b0;
    w_irqSet   = 1'b0;
    if (w_stepDone) begin
      w_stepNext = (r_step == apuLastStep(r_mode)) ? 3'd0 : (r_step + 3'd1);
      case (r_step)
        3'd0: w_quarter = 1'b1;
        3'd1: begin
          w_quarter = 1'b1;
          w_half    = 1'b1;
        end
        3'd2: w_quarter = 1'b1;
        3'd3: begin
          // Step 3 is silent in 5-step mode and ends the frame in 4-step mode.
          if (r_mode == APU_MODE_4STEP) begin
            w_quarter = 1'b1;
            w_half    = 1'b1;
            w_irqSet  = 1'b1;
          end
        end
        3'd4: begin
          w_quarter = 1'b1;
          w_half    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_step    <= 3'd0;
      r_mode    <= APU_MODE_4STEP;
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
    end else begin
      // w_stepDone is already suppressed by iWrite, so the write's immediate
      // 5-step clock is the only strobe source in a write cycle.
      r_quarter <= w_quarter | (iWrite & iMode);
      r_half    <= w_half    | (iWrite & iMode);
      if (iWrite) begin
        r_mode <= apuMode_t'(iMode);
        r_step <= 3'd0;
      end else begin
        r_step <= w_stepNext;
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic r_inhibit;
  logic r_irqFlag;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_inhibit <= 1'b0;
      r_irqFlag <= 1'b0;
    end else begin
      if (iWrite) begin
        r_inhibit <= iIrqInhibit;
      end
      // Priority: inhibiting write clears, then frame-end set, then ack.
      if (iWrite && iIrqInhibit) begin
        r_irqFlag <= 1'b0;
      end else if (w_irqSet && !r_inhibit) begin
        r_irqFlag <= 1'b1;
      end else if (iIrqAck) begin
        r_irqFlag <= 1'b0;
      end
    end
  end

  assign oIrq = r_irqFlag;
`else
  logic w_unusedIrqInputs;
  assign w_unusedIrqInputs = iIrqInhibit ^ iIrqAck ^ w_irqSet;
  assign oIrq = 1'b0;
`endif

  assign oQuarterFrame = r_quarter;
  assign oHalfFrame    = r_half;
  assign oStep         = r_step;
  assign oMode         = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_apu_frame_sequencer                                     |
// | Description : Directed self-checking bench for apu_frame_sequencer with  |
// |               STEP_PERIOD=4. Observed vector is {Q,H,Irq,Step[2:0],Mode}.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_apu_frame_sequencer;

  localparam int P = 4;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       iClk        = 1'b0;
  logic       iReset_n    = 1'b0;
  logic       iCpuTick    = 1'b0;
  logic       iWrite      = 1'b0;
  logic       iMode       = 1'b0;
  logic       iIrqInhibit = 1'b0;
  logic       iIrqAck     = 1'b0;
  logic       oQuarterFrame;
  logic       oHalfFrame;
  logic       oIrq;
  logic [2:0] oStep;
  logic       oMode;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] obs;
  logic [6:0] exp;
  assign obs = {oQuarterFrame, oHalfFrame, oIrq, oStep, oMode};

  always #5 iClk = ~iClk;

  apu_frame_sequencer #(
    .STEP_PERIOD (P)
  ) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iCpuTick      (iCpuTick),
    .iWrite        (iWrite),
    .iMode         (iMode),
    .iIrqInhibit   (iIrqInhibit),
    .iIrqAck       (iIrqAck),
    .oQuarterFrame (oQuarterFrame),
    .oHalfFrame    (oHalfFrame),
    .oIrq          (oIrq),
    .oStep         (oStep),
    .oMode         (oMode)
  );

  function automatic logic [6:0] pack(input bit q, input bit h, input bit irq,
                                      input int step, input bit mode);
    return {q, h, irq, 3'(step), mode};
  endfunction

  task automatic clk1();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0;
    clk1();
    clk1();
    exp = 7'd0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset obs=%b exp=%b", obs, exp);
    end
    iReset_n = 1'b1;
  endtask

  task automatic test_4step();
    iCpuTick = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      clk1();
      exp = pack(t % 4 == 0, t % 8 == 0, IRQ_EN && t >= 16, (t / 4) % 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL 4step t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_irq_ack();
    for (int t = 17; t <= 32; t++) begin
      iIrqAck = (t == 17) || (t == 32);
      clk1();
      iIrqAck = 1'b0;
      exp = pack(t % 4 == 0, t % 8 == 0, IRQ_EN && t == 32, (t / 4) % 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL irq_ack t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_5step();
    iWrite  = 1'b1;
    iMode   = 1'b1;
    iIrqAck = 1'b1;
    clk1();
    iWrite  = 1'b0;
    iIrqAck = 1'b0;
    exp = pack(1'b1, 1'b1, 1'b0, 0, 1'b1);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL 5step_write obs=%b exp=%b", obs, exp);
    end
    for (int t = 1; t <= 60; t++) begin
      int p;
      clk1();
      p = t % 20;
      exp = pack(p == 4 || p == 8 || p == 12 || p == 0, p == 8 || p == 0, 1'b0,
                 (t / 4) % 5, 1'b1);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL 5step t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_write_mid();
    iWrite = 1'b1;
    iMode  = 1'b0;
    clk1();
    iWrite = 1'b0;
    exp = 7'd0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL wr4_realign obs=%b exp=%b", obs, exp);
    end
    for (int t = 1; t <= 10; t++) begin
      clk1();
      exp = pack(t % 4 == 0, t == 8, 1'b0, t / 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL pre_mid t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
    iWrite      = 1'b1;
    iIrqInhibit = 1'b1;
    clk1();
    iWrite      = 1'b0;
    iIrqInhibit = 1'b0;
    exp = 7'd0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL write_mid obs=%b exp=%b", obs, exp);
    end
    for (int t = 1; t <= 16; t++) begin
      clk1();
      exp = pack(t % 4 == 0, t % 8 == 0, 1'b0, (t / 4) % 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL inhibited t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 1; t <= 7; t++) begin
      clk1();
      exp = pack(t == 4, 1'b0, 1'b0, t / 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL pre_coll t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
    // Write lands on the step-1 end tick: its Q+H must be discarded.
    iWrite = 1'b1;
    clk1();
    iWrite = 1'b0;
    exp = 7'd0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL write_vs_step obs=%b exp=%b", obs, exp);
    end
    iWrite = 1'b1;
    iMode  = 1'b1;
    clk1();
    iWrite = 1'b0;
    iMode  = 1'b0;
    exp = pack(1'b1, 1'b1, 1'b0, 0, 1'b1);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL strobe_before_rst obs=%b exp=%b", obs, exp);
    end
    iReset_n = 1'b0;
    #1;
    exp = 7'd0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL async_reset obs=%b exp=%b", obs, exp);
    end
    @(negedge iClk);
    iReset_n = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      clk1();
      exp = pack(t == 4, 1'b0, 1'b0, t / 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL post_rst t=%0d obs=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_sparse();
    iReset_n = 1'b0;
    iCpuTick = 1'b0;
    clk1();
    @(negedge iClk);
    iReset_n = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      int k;
      bit tk;
      tk = (c % 3 == 0);
      iCpuTick = tk;
      clk1();
      k = c / 3;
      exp = pack(tk && k % 4 == 0, tk && k % 8 == 0, IRQ_EN && k >= 16,
                 (k / 4) % 4, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL sparse c=%0d obs=%b exp=%b", c, obs, exp);
      end
    end
    iCpuTick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_4step();
    test_irq_ack();
    test_5step();
    test_write_mid();
    test_back_to_back();
    test_sparse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=%b exp=finish", obs);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
